// File: rtl/abt_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state encoding, default parameter values, one-hot to index helper.
package abt_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_LOCK = 2'd2
    } st_e;

    localparam int NM_DEF       = 16;
    localparam int TOUT_MAX_DEF = 255;
    localparam int CW_DEF       = 8;

    // OR-reduce the positions of set bits; exact for a one-hot input,
    // yields 0 for an all-zero input.
    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/abt_rr_pick.sv
// Rotating priority pick: first requester strictly after ptr, wrapping modulo NM.
// Latency: purely combinational.
// Backpressure: none; parks on master 0 when nothing requests.
// Ports: req (NM request bits), ptr (last granted index) -> gnt (one-hot), vld (any request).
module rr_pick #(
    parameter int NM = 16
) (
    input  logic [NM-1:0]         req,
    input  logic [$clog2(NM)-1:0] ptr,
    output logic [NM-1:0]         gnt,
    output logic                  vld
);

    localparam int IW = $clog2(NM);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        gnt[0] = 1'b1;
        found = 1'b0;
        idx   = '0;
        vld   = |req;
        // Offsets 1..NM visit every master once, ending on ptr itself,
        // so a lone requester is always re-granted.
        for (int i = 1; i <= NM; i++) begin
            idx = IW'((int'(ptr) + i) % NM);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/abt_rr.sv
// Round-robin bus arbiter with lock support and error/timeout forced re-arbitration.
// Latency: AxGNT combinational from MmLST/MsERR; AmCMUX/AmIDX/AmLOCK/AmTOUT one edge later.
// Backpressure: MsRDY low holds AmCMUX and runs the wait counter; TOUT_MAX stalls force re-arbitration.
// Ports: CLK, RST (async high); MxREQ, MmLK, MmLST, MsRDY, MsERR in;
//        AxGNT (one-hot comb), AmCMUX (one-hot reg), AmIDX, AmLOCK, AmTOUT out.
module abt_rr
    import abt_rr_pkg::*;
#(
    parameter int NM       = NM_DEF,
    parameter int TOUT_MAX = TOUT_MAX_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NM-1:0]         MxREQ,
    input  logic                  MmLK,
    input  logic                  MmLST,
    input  logic                  MsRDY,
    input  logic                  MsERR,
    output logic [NM-1:0]         AxGNT,
    output logic [NM-1:0]         AmCMUX,
    output logic [$clog2(NM)-1:0] AmIDX,
    output logic                  AmLOCK,
    output logic                  AmTOUT
);

    localparam int IW = $clog2(NM);

    logic [NM-1:0] l_gnt_q, l_gnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    st_e           st_q, st_d;
    logic [NM-1:0] cmux_q, cmux_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          tout_q, tout_d;

    logic [NM-1:0] next_gnt;
    logic          next_vld;
    logic          tout;
    logic          new_abt;
    logic [NM-1:0] gnt;

    rr_pick #(.NM(NM)) u_pick (
        .req (MxREQ),
        .ptr (ptr_q),
        .gnt (next_gnt),
        .vld (next_vld)
    );

    always_comb begin
        tout    = (cnt_q == CW'(TOUT_MAX));
        // Error and timeout override the lock qualifier.
        new_abt = MsERR | tout | (MmLST & ~MmLK);
        gnt     = new_abt ? next_gnt : l_gnt_q;

        // A locked last transfer re-latches the same owner, since gnt == l_gnt_q then.
        l_gnt_d = (MmLST | MsERR | tout) ? gnt : l_gnt_q;
        // Parking on master 0 with no requesters leaves the pointer alone.
        ptr_d   = (new_abt && next_vld) ? IW'(oh2idx(16'(next_gnt))) : ptr_q;
        cmux_d  = MsRDY ? gnt : cmux_q;
        idx_d   = IW'(oh2idx(16'(l_gnt_d)));
        tout_d  = tout;

        if (MsRDY || new_abt || st_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TOUT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        st_d = st_q;
        case (st_q)
            ST_IDLE: begin
                if (next_vld) st_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (MmLST && MmLK && !MsERR && !tout) begin
                    st_d = ST_LOCK;
                end else if (new_abt && !next_vld) begin
                    st_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                // Lock exit conditions are exactly the re-arbitration triggers.
                if (new_abt) st_d = next_vld ? ST_BUSY : ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            l_gnt_q <= NM'(1);
            ptr_q   <= IW'(NM - 1);
            cnt_q   <= '0;
            st_q    <= ST_IDLE;
            cmux_q  <= NM'(1);
            idx_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            l_gnt_q <= l_gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            cmux_q  <= cmux_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
        end
    end

    assign AxGNT  = gnt;
    assign AmCMUX = cmux_q;
    assign AmIDX  = idx_q;
    assign AmLOCK = (st_q == ST_LOCK);
    assign AmTOUT = tout_q;

endmodule

// File: doc/abt_rr.md
# abt_rr

Round-robin bus arbiter for the shared master-to-slave bus. It grants ownership among up to NM requesting masters and honours locked transactions. It forces re-arbitration on slave error or on a wait-state timeout, and drives the registered master-select to the command mux. It is a drop-in peer of the fixed-priority arbiter, for configurations where fairness across masters is required.

## Interface
- NM, 16: number of masters, 2..16.
- TOUT_MAX, 255: consecutive not-ready cycles tolerated before a forced re-arbitration. Must be ≥ 1.
- CW, 8: timeout counter width. TOUT_MAX < 2^CW.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- MxREQ  in  NM  bus request, one bit per master.
- MmLK  in  1  current owner's lock qualifier.
- MmLST  in  1  last transfer of the current owner's transaction.
- MsRDY  in  1  slave ready.
- MsERR  in  1  slave error response.
- AxGNT  out  NM  one-hot grant, combinational.
- AmCMUX  out  NM  one-hot command-mux select, registered.
- AmIDX  out  $clog2(NM)  binary index of the L_GNT owner, registered.
- AmLOCK  out  1  high while the bus is locked to its owner (state LOCK).
- AmTOUT  out  1  one-cycle pulse, registered, when a timeout forced re-arbitration.

## Operation
- Registers:
  - L_GNT: latched one-hot grant.
  - PTR: index of the last master granted while it requested.
  - CNT: wait counter.
  - ST: state, one of IDLE, BUSY, LOCK.
- NEXT_GNT (combinational): scan MxREQ from index PTR+1 upward, wrapping modulo NM, and pick the first requester. If no bit is set, NEXT_GNT is one-hot master 0 (park).
- TOUT = (CNT == TOUT_MAX).
- NEW_ABT = MsERR | TOUT | (MmLST & ~MmLK).
- AxGNT = NEW_ABT ? NEXT_GNT : L_GNT, in the same cycle.
- L_GNT update: L_GNT <= AxGNT when MmLST | MsERR | TOUT.
- PTR update: when NEW_ABT and MxREQ has at least one bit set, PTR <= index(NEXT_GNT). Parking on master 0 does not move PTR.
- AmCMUX update: AmCMUX <= AxGNT when MsRDY; otherwise it holds.
- CNT:
  - Cleared on MsRDY, on NEW_ABT, or when ST = IDLE.
  - Otherwise incremented, saturating at TOUT_MAX.
- AmTOUT <= TOUT, every cycle.
- AmIDX is the registered binary encoding of L_GNT's next value.
- State transitions, evaluated at the clock edge:
  - IDLE -> BUSY when MxREQ != 0.
  - BUSY -> LOCK on MmLST & MmLK & ~MsERR & ~TOUT.
  - BUSY -> IDLE on NEW_ABT with MxREQ == 0.
  - LOCK -> BUSY on MsERR, TOUT, or MmLST & ~MmLK, when MxREQ != 0.
  - LOCK -> IDLE on the same exit conditions when MxREQ == 0.
  - AmLOCK = (ST == LOCK).
- Priority rules:
  - MsERR and TOUT override MmLK; a lock never survives an error or a timeout.
  - MmLST & MmLK without error keeps the current owner.
- A requester drops out only by deasserting MxREQ. The grant is not revoked mid-transaction except by MsERR or TOUT.

## Timing
- Reset values (asynchronous, effective immediately):
  - L_GNT = AmCMUX = one-hot 0.
  - PTR = NM-1, so the first scan starts at master 0.
  - CNT = 0, AmTOUT = 0, AmIDX = 0, ST = IDLE, AmLOCK = 0.
- AxGNT changes in the cycle NEW_ABT rises: zero latency from MmLST/MsERR.
- AmCMUX follows AxGNT one edge later, and only on MsRDY.
- AmTOUT pulses in the cycle after CNT reaches TOUT_MAX. CNT is 0 in that same cycle.
- Simultaneous events:
  - MsERR with MmLST & MmLK: MsERR wins, re-arbitrate.
  - TOUT with MsRDY: TOUT still fires, because CNT was already at max.
- Wrap-around: with PTR = NM-1, the scan starts at index 0.
- Single requester: it is re-granted on every arbitration.
- Reset asserted mid-transaction: all state returns to reset values in the same cycle, and AxGNT becomes one-hot 0 because NEW_ABT is not asserted.

## Structure
- Shared bus package holds:
  - State encodings: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_LOCK=2'd2.
  - Default NM and TOUT_MAX constants.
  - A one-hot-to-index function.
- One sub-module, rr_pick: combinational rotate-and-priority-encode.
  - Inputs: NM-bit request vector and PTR.
  - Outputs: one-hot NEXT_GNT and a valid flag.
- Everything else (registers, FSM, counter) lives in abt_rr.

## Test plan
- Reset release, no requests: AxGNT = AmCMUX = 16'h0001, ST = IDLE, AmLOCK = 0.
- MxREQ = 16'h0007 throughout, MmLST pulsed every 4 cycles with MmLK = 0, MsRDY = 1: grants cycle 0x0001 -> 0x0002 -> 0x0004 -> 0x0001, one master per transaction.
- Owner master 2 issues MmLST & MmLK with MxREQ = 16'h0007: grant stays 0x0004 and AmLOCK = 1. The next MmLST with MmLK = 0 grants 0x0001.
- Locked owner, MsERR pulsed while MmLK = 1: AxGNT switches to NEXT_GNT in that cycle and AmLOCK drops at the next edge.
- Owner holds with MsRDY = 0 for TOUT_MAX cycles (TOUT_MAX = 4): grant moves on cycle 5, AmTOUT = 1 for exactly one cycle, CNT = 0.
- RST asserted mid-transfer with MxREQ = 16'h8000 granted: outputs return to reset values immediately. After release, master 15 is granted at the first arbitration.
